// File: rtl/riscv_exmem_stage.sv
// riscv_exmem_stage
//   EX->MEM pipeline register of the RV32I 5-stage core. It latches the execute-stage
//   results and turns the raw rs2 store operand into lane-replicated write data plus byte
//   enables. Misaligned or illegal-width accesses are suppressed, and a one-cycle
//   misalign flag is raised for the trap logic.
//   Update priority on each rising edge: reset > flush > stall > normal load.
// Ports
//   i_clk, i_rstn                 clock; synchronous active-low reset
//   i_stall_m, i_flush_m          hold all M registers / insert a bubble (flush wins)
//   i_*_e                         execute-stage results and control
//   o_alu_result_m                registered address or ALU result (dmem address)
//   o_write_data_m                lane-replicated store data (dmem data)
//   o_mem_write_m, o_mem_read_m   qualified access strobes (0 if misaligned)
//   o_mem_byte_sel_m              byte enables, bit n = byte lane n
//   o_misalign_m                  access misaligned or of illegal width
//   o_funct3_m ... o_pc_plus4_m   registered pass-through copies

`ifndef XLEN
`define XLEN 32
`endif

module riscv_exmem_stage (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_stall_m,
  input  logic              i_flush_m,
  input  logic [`XLEN-1:0]  i_alu_result_e,
  input  logic [`XLEN-1:0]  i_write_data_e,
  input  logic              i_mem_write_e,
  input  logic              i_mem_read_e,
  input  logic [2:0]        i_funct3_e,
  input  logic              i_reg_write_e,
  input  logic [1:0]        i_result_src_e,
  input  logic [4:0]        i_rd_e,
  input  logic [`XLEN-1:0]  i_pc_plus4_e,
  output logic [`XLEN-1:0]  o_alu_result_m,
  output logic [`XLEN-1:0]  o_write_data_m,
  output logic              o_mem_write_m,
  output logic              o_mem_read_m,
  output logic [3:0]        o_mem_byte_sel_m,
  output logic              o_misalign_m,
  output logic [2:0]        o_funct3_m,
  output logic              o_reg_write_m,
  output logic [1:0]        o_result_src_m,
  output logic [4:0]        o_rd_m,
  output logic [`XLEN-1:0]  o_pc_plus4_m
);

  localparam int unsigned Xlen = `XLEN;

  // Execute-side lane formatting
  logic              mem_access;
  logic [1:0]        addr_lo;
  logic [3:0]        sel_e;
  logic [Xlen-1:0]   wdata_e;
  logic              misalign_e;

  assign mem_access = i_mem_write_e | i_mem_read_e;
  assign addr_lo    = i_alu_result_e[1:0];

  always_comb begin
    sel_e      = 4'b0000;
    wdata_e    = i_write_data_e;
    misalign_e = 1'b0;
    if (mem_access) begin
      unique case (i_funct3_e[1:0])
        2'b00: begin
          sel_e   = 4'b0001 << addr_lo;
          wdata_e = {4{i_write_data_e[7:0]}};
        end
        2'b01: begin
          sel_e      = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_e    = {2{i_write_data_e[15:0]}};
          misalign_e = addr_lo[0];
        end
        2'b10: begin
          sel_e      = 4'b1111;
          misalign_e = |addr_lo;
        end
        default: begin
          misalign_e = 1'b1;
        end
      endcase
      // A faulting access must not touch any lane.
      if (misalign_e) sel_e = 4'b0000;
    end
  end

  // Memory-stage registers
  logic [Xlen-1:0] alu_result_q;
  logic [Xlen-1:0] write_data_q;
  logic            mem_write_q;
  logic            mem_read_q;
  logic [3:0]      byte_sel_q;
  logic            misalign_q;
  logic [2:0]      funct3_q;
  logic            reg_write_q;
  logic [1:0]      result_src_q;
  logic [4:0]      rd_q;
  logic [Xlen-1:0] pc_plus4_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      byte_sel_q   <= 4'b0000;
      misalign_q   <= 1'b0;
      funct3_q     <= 3'b000;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      rd_q         <= 5'd0;
      pc_plus4_q   <= '0;
    end else if (i_flush_m) begin
      // Bubble: only control is cleared; data fields keep their old contents.
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      byte_sel_q   <= 4'b0000;
      misalign_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
    end else if (!i_stall_m) begin
      alu_result_q <= i_alu_result_e;
      write_data_q <= wdata_e;
      mem_write_q  <= i_mem_write_e & ~misalign_e;
      mem_read_q   <= i_mem_read_e & ~misalign_e;
      byte_sel_q   <= sel_e;
      misalign_q   <= misalign_e;
      funct3_q     <= i_funct3_e;
      reg_write_q  <= i_reg_write_e & ~misalign_e;
      result_src_q <= i_result_src_e;
      rd_q         <= i_rd_e;
      pc_plus4_q   <= i_pc_plus4_e;
    end
  end

  assign o_alu_result_m   = alu_result_q;
  assign o_write_data_m   = write_data_q;
  assign o_mem_write_m    = mem_write_q;
  assign o_mem_read_m     = mem_read_q;
  assign o_mem_byte_sel_m = byte_sel_q;
  assign o_misalign_m     = misalign_q;
  assign o_funct3_m       = funct3_q;
  assign o_reg_write_m    = reg_write_q;
  assign o_result_src_m   = result_src_q;
  assign o_rd_m           = rd_q;
  assign o_pc_plus4_m     = pc_plus4_q;

endmodule

// File: tb/tb_riscv_exmem_stage.sv
// Bench for riscv_exmem_stage: directed cases followed by randomized traffic, all checked
// against a behavioural model of the M-stage register contents.

`timescale 1ns/1ps

module tb_riscv_exmem_stage;

  logic        clk = 1'b0;
  logic        rstn, stall, flush;
  logic [31:0] alu_e, wd_e, pc_e;
  logic        mw_e, mr_e, rw_e;
  logic [2:0]  f3_e;
  logic [1:0]  rs_e;
  logic [4:0]  rd_e;

  logic [31:0] alu_m, wd_m, pc_m;
  logic        mw_m, mr_m, mis_m, rw_m;
  logic [3:0]  sel_m;
  logic [2:0]  f3_m;
  logic [1:0]  rs_m;
  logic [4:0]  rd_m;

  // Model state
  logic [31:0] x_alu, x_wd, x_pc;
  logic        x_mw, x_mr, x_mis, x_rw;
  logic [3:0]  x_sel;
  logic [2:0]  x_f3;
  logic [1:0]  x_rs;
  logic [4:0]  x_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_exmem_stage dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_stall_m        (stall),
    .i_flush_m        (flush),
    .i_alu_result_e   (alu_e),
    .i_write_data_e   (wd_e),
    .i_mem_write_e    (mw_e),
    .i_mem_read_e     (mr_e),
    .i_funct3_e       (f3_e),
    .i_reg_write_e    (rw_e),
    .i_result_src_e   (rs_e),
    .i_rd_e           (rd_e),
    .i_pc_plus4_e     (pc_e),
    .o_alu_result_m   (alu_m),
    .o_write_data_m   (wd_m),
    .o_mem_write_m    (mw_m),
    .o_mem_read_m     (mr_m),
    .o_mem_byte_sel_m (sel_m),
    .o_misalign_m     (mis_m),
    .o_funct3_m       (f3_m),
    .o_reg_write_m    (rw_m),
    .o_result_src_m   (rs_m),
    .o_rd_m           (rd_m),
    .o_pc_plus4_m     (pc_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access of 2^w bytes must sit on a 2^w boundary; sub-word data is copied into every lane.
  task automatic model_edge();
    int unsigned size;
    logic        mis;
    logic [3:0]  sel;
    logic [31:0] wd;
    if (!rstn) begin
      {x_alu, x_wd, x_pc} = '0;
      {x_mw, x_mr, x_mis, x_rw} = '0;
      x_sel = '0; x_f3 = '0; x_rs = '0; x_rd = '0;
    end else if (flush) begin
      x_mw = 0; x_mr = 0; x_rw = 0; x_mis = 0; x_sel = 0; x_rs = 0;
    end else if (!stall) begin
      mis = 0; sel = 0; wd = wd_e;
      if (mw_e || mr_e) begin
        if (f3_e[1:0] == 2'd3) begin
          mis = 1;
        end else begin
          size = 1 << f3_e[1:0];
          mis  = (alu_e % size) != 0;
          for (int i = 0; i < 4; i++) wd[8*i +: 8] = wd_e[8*(i % size) +: 8];
          if (!mis) sel = 4'(((1 << size) - 1) << (alu_e % 4));
        end
      end
      x_alu = alu_e; x_wd = wd; x_sel = sel; x_mis = mis;
      x_mw = mw_e && !mis; x_mr = mr_e && !mis; x_rw = rw_e && !mis;
      x_f3 = f3_e; x_rs = rs_e; x_rd = rd_e; x_pc = pc_e;
    end
  endtask

  task automatic check_all();
    check("alu_result", alu_m, x_alu);
    check("write_data", wd_m, x_wd);
    check("mem_write", 32'(mw_m), 32'(x_mw));
    check("mem_read", 32'(mr_m), 32'(x_mr));
    check("byte_sel", 32'(sel_m), 32'(x_sel));
    check("misalign", 32'(mis_m), 32'(x_mis));
    check("funct3", 32'(f3_m), 32'(x_f3));
    check("reg_write", 32'(rw_m), 32'(x_rw));
    check("result_src", 32'(rs_m), 32'(x_rs));
    check("rd", 32'(rd_m), 32'(x_rd));
    check("pc_plus4", pc_m, x_pc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic mw, input logic mr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic rw);
    mw_e = mw; mr_e = mr; f3_e = f3; alu_e = addr; wd_e = rs2; rw_e = rw;
    rs_e = mr ? 2'd1 : 2'd0;
    rd_e = 5'($urandom_range(1, 31));
    pc_e = $urandom;
  endtask

  initial begin
    rstn = 0; stall = 0; flush = 0;
    drive(1, 0, 3'b010, 32'h44, 32'h1234_5678, 1);
    step();
    check("reset_alu_zero", alu_m, 32'h0);
    check("reset_pc_zero", pc_m, 32'h0);
    rstn = 1;

    // SB to lane 3
    drive(1, 0, 3'b000, 32'h103, 32'hAABB_CCDD, 0);
    step();
    check("sb_sel", 32'(sel_m), 32'h8);
    check("sb_wdata", wd_m, 32'hDDDD_DDDD);
    check("sb_mw", 32'(mw_m), 32'h1);

    // SH upper half, then misaligned SH
    drive(1, 0, 3'b001, 32'h102, 32'h1234_5678, 0);
    step();
    check("sh_sel", 32'(sel_m), 32'hC);
    check("sh_wdata", wd_m, 32'h5678_5678);
    drive(1, 0, 3'b001, 32'h101, 32'h1234_5678, 1);
    step();
    check("sh_mis", 32'(mis_m), 32'h1);
    check("sh_mis_mw", 32'(mw_m), 32'h0);
    check("sh_mis_rw", 32'(rw_m), 32'h0);

    // LW aligned then misaligned
    drive(0, 1, 3'b010, 32'h200, 32'h0, 1);
    step();
    check("lw_mr", 32'(mr_m), 32'h1);
    check("lw_sel", 32'(sel_m), 32'hF);
    check("lw_rw", 32'(rw_m), 32'h1);
    drive(0, 1, 3'b010, 32'h202, 32'h0, 1);
    step();
    check("lw_mis", 32'(mis_m), 32'h1);
    check("lw_mis_alu", alu_m, 32'h202);

    // SW latched, then held through three stalled edges
    drive(1, 0, 3'b010, 32'h10, 32'hCAFE_F00D, 0);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 3'b000, 32'h20 + i, $urandom, 1);
      step();
    end
    check("stall_alu", alu_m, 32'h10);
    check("stall_wdata", wd_m, 32'hCAFE_F00D);
    check("stall_mw", 32'(mw_m), 32'h1);

    // Flush beats stall
    flush = 1;
    drive(1, 0, 3'b010, 32'h40, 32'h1111_1111, 1);
    step();
    check("flush_mw", 32'(mw_m), 32'h0);
    check("flush_alu_held", alu_m, 32'h10);
    flush = 0;

    // Reset while stalled, then reload
    rstn = 0;
    step();
    check("rst_stall_sel", 32'(sel_m), 32'h0);
    rstn = 1; stall = 0;
    drive(0, 1, 3'b100, 32'h301, 32'h0, 1);
    step();
    check("post_rst_alu", alu_m, 32'h301);
    check("post_rst_lbu_sel", 32'(sel_m), 32'h2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rstn  = ($urandom_range(0, 39) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 2))
        0:       drive(0, 0, 3'($urandom), $urandom, $urandom, 1'($urandom));
        1:       drive(1, 0, 3'($urandom), $urandom, $urandom, 1'($urandom));
        default: drive(0, 1, 3'($urandom), $urandom, $urandom, 1'($urandom));
      endcase
      rs_e = 2'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
